// File: rtl/read_handler_if.sv
// Read-side FIFO bus: consumer handshake, incoming write Gray pointer and
// the read-domain pointer/flag outputs.
interface read_handler_if #(
  parameter int ADRESSS_SIZE = 5
);
  logic                    read_enable;
  logic [ADRESSS_SIZE:0]   write_gpointer;
  logic [ADRESSS_SIZE-1:0] read_address;
  logic [ADRESSS_SIZE:0]   read_pointer;
  logic                    read_empty;
  logic                    read_almost_empty;
  logic [ADRESSS_SIZE:0]   read_count;
  logic                    read_underflow;

  modport slave (
    input  read_enable, write_gpointer,
    output read_address, read_pointer, read_empty, read_almost_empty,
           read_count, read_underflow
  );

  modport master (
    output read_enable, write_gpointer,
    input  read_address, read_pointer, read_empty, read_almost_empty,
           read_count, read_underflow
  );
endinterface

// File: rtl/read_handler.sv
// Read-domain pointer and flag logic of an asynchronous FIFO: synchronises the
// write Gray pointer, advances the read pointer and registers the status flags.
module read_handler #(
  parameter int ADRESSS_SIZE       = 5,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input logic           read_clock,
  input logic           reset,
  read_handler_if.slave bus
);
  localparam int AW = ADRESSS_SIZE;
  localparam logic [AW:0] AE_LEVEL = (AW+1)'(ALMOST_EMPTY_LEVEL);

  logic [AW:0] sync1_reg, sync2_reg;
  logic [AW:0] binary_reg, gray_reg, count_reg;
  logic        empty_reg, almost_empty_reg, underflow_reg;

  logic [AW:0] wbin;
  logic        read_accept;
  logic [AW:0] binary_next, gray_next, count_next;
  logic        empty_next, almost_empty_next;

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin     = '0;
    wbin[AW] = sync2_reg[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ sync2_reg[i];
    end
  end

  always_comb begin
    read_accept       = bus.read_enable && !empty_reg;
    binary_next       = binary_reg + {{AW{1'b0}}, read_accept};
    gray_next         = (binary_next >> 1) ^ binary_next;
    empty_next        = (gray_next == sync2_reg);
    count_next        = wbin - binary_next;
    almost_empty_next = (count_next <= AE_LEVEL);
  end

  always_ff @(posedge read_clock) begin
    if (reset) begin
      sync1_reg        <= '0;
      sync2_reg        <= '0;
      binary_reg       <= '0;
      gray_reg         <= '0;
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      almost_empty_reg <= 1'b1;
      underflow_reg    <= 1'b0;
    end else begin
      sync1_reg        <= bus.write_gpointer;
      sync2_reg        <= sync1_reg;
      binary_reg       <= binary_next;
      gray_reg         <= gray_next;
      count_reg        <= count_next;
      empty_reg        <= empty_next;
      almost_empty_reg <= almost_empty_next;
      underflow_reg    <= bus.read_enable && empty_reg;
    end
  end

  assign bus.read_address      = binary_reg[AW-1:0];
  assign bus.read_pointer      = gray_reg;
  assign bus.read_empty        = empty_reg;
  assign bus.read_almost_empty = almost_empty_reg;
  assign bus.read_count        = count_reg;
  assign bus.read_underflow    = underflow_reg;
endmodule
